// File: rtl/l2_fill_if.sv
// Bundle of the I-cache / D-cache fill handshakes and the shared L2 fill port.
// The slave side is the arbiter; the master side is the L1 miss handlers plus the L2 model.
interface l2_fill_if #(
  parameter int LINE_BITS = 256
);
  logic                 ic_req_i;
  logic [31:0]          ic_addr_i;
  logic [LINE_BITS-1:0] ic_data_o;
  logic                 ic_ready_o;
  logic                 dc_req_i;
  logic [31:0]          dc_addr_i;
  logic [LINE_BITS-1:0] dc_data_o;
  logic                 dc_ready_o;
  logic [31:0]          l2_addr_o;
  logic                 l2_re_o;
  logic [LINE_BITS-1:0] l2_data_i;
  logic                 l2_data_ready_i;

  modport slave (
    input  ic_req_i, ic_addr_i, dc_req_i, dc_addr_i, l2_data_i, l2_data_ready_i,
    output ic_data_o, ic_ready_o, dc_data_o, dc_ready_o, l2_addr_o, l2_re_o
  );

  modport master (
    output ic_req_i, ic_addr_i, dc_req_i, dc_addr_i, l2_data_i, l2_data_ready_i,
    input  ic_data_o, ic_ready_o, dc_data_o, dc_ready_o, l2_addr_o, l2_re_o
  );
endinterface

// File: rtl/l2_fill_arbiter.sv
// Round-robin arbiter sharing one L2 line-fill port between I-cache and D-cache,
// one fill in flight, with a watchdog that completes a lost fill with zero data.
module l2_fill_arbiter #(
  parameter int LINE_BITS   = 256,
  parameter int OFFSET_BITS = 5,
  parameter int TIMEOUT     = 64
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    run_i,
  l2_fill_if.slave bus,
  output logic    busy_o,
  output logic    err_o
);
  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]     LINE_MASK = 32'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic             owner_dc;
  logic             last_dc;
  logic [CNT_W-1:0] wd_cnt;
  logic             grant_dc;
  logic [31:0]      grant_addr;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_dc   = bus.dc_req_i && (!bus.ic_req_i || !last_dc);
    grant_addr = (grant_dc ? bus.dc_addr_i : bus.ic_addr_i) & ~LINE_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      owner_dc       <= 1'b0;
      last_dc        <= 1'b1;
      wd_cnt         <= '0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
      bus.ic_ready_o <= 1'b0;
      bus.dc_ready_o <= 1'b0;
      bus.ic_data_o  <= '0;
      bus.dc_data_o  <= '0;
      bus.l2_addr_o  <= '0;
      bus.l2_re_o    <= 1'b0;
    end else begin
      bus.ic_ready_o <= 1'b0;
      bus.dc_ready_o <= 1'b0;
      bus.l2_re_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (run_i && (bus.ic_req_i || bus.dc_req_i)) begin
            owner_dc      <= grant_dc;
            last_dc       <= grant_dc;
            bus.l2_addr_o <= grant_addr;
            bus.l2_re_o   <= 1'b1;
            wd_cnt        <= '0;
            busy_o        <= 1'b1;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // A response on the last allowed cycle beats the watchdog.
          if (bus.l2_data_ready_i || wd_cnt == CNT_LAST) begin
            if (owner_dc) begin
              bus.dc_data_o  <= bus.l2_data_ready_i ? bus.l2_data_i : '0;
              bus.dc_ready_o <= 1'b1;
            end else begin
              bus.ic_data_o  <= bus.l2_data_ready_i ? bus.l2_data_i : '0;
              bus.ic_ready_o <= 1'b1;
            end
            if (!bus.l2_data_ready_i) err_o <= 1'b1;
            state <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_l2_fill_arbiter.sv
// Randomized bench for l2_fill_arbiter against a transaction-level model of grants,
// aligned addresses, response latency, watchdog and held data.
module tb_l2_fill_arbiter;
  localparam int LB = 64;
  localparam int OB = 5;
  localparam int TO = 4;
  localparam logic [31:0] LINE_BYTES = 32'd32;

  logic clk = 1'b0;
  logic reset, run;
  logic busy, err;

  l2_fill_if #(.LINE_BITS(LB)) bus();

  l2_fill_arbiter #(.LINE_BITS(LB), .OFFSET_BITS(OB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run_i(run), .bus(bus), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  bit          m_last_dc;
  bit          m_err;
  logic [LB-1:0] m_data [2];
  logic [31:0] m_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last_dc = 1'b1;
    m_err     = 1'b0;
    m_data[0] = '0;
    m_data[1] = '0;
    m_addr    = '0;
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, "_ic_ready"}, 64'(bus.ic_ready_o), 64'd0);
    chk({tag, "_dc_ready"}, 64'(bus.dc_ready_o), 64'd0);
    chk({tag, "_re"},       64'(bus.l2_re_o), 64'd0);
    chk({tag, "_busy"},     64'(busy), 64'd0);
    chk({tag, "_err"},      64'(err), 64'(m_err));
    chk({tag, "_addr"},     64'(bus.l2_addr_o), 64'(m_addr));
    chk({tag, "_ic_data"},  bus.ic_data_o, m_data[0]);
    chk({tag, "_dc_data"},  bus.dc_data_o, m_data[1]);
  endtask

  // One cycle in which no grant may happen; L2 noise must be ignored.
  task automatic idle_tick();
    bus.l2_data_ready_i = 1'($urandom_range(0, 1));
    bus.l2_data_i       = {$urandom, $urandom};
    tick();
    bus.l2_data_ready_i = 1'b0;
    check_idle_outs("idle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ic_req_i = 1'b0;
    bus.dc_req_i = 1'b0;
    bus.l2_data_ready_i = 1'b0;
    tick();
    reset = 1'b0;
    run   = 1'b1;
    model_reset();
    check_idle_outs("rst");
  endtask

  // Full fill: grant at the next edge, L2 answers after lat idle WAIT cycles
  // (or never), then RESP and one IDLE cycle.
  task automatic do_fill(input int lat, input bit respond, input bit kill_run, output bit won_dc);
    int            n;
    logic [31:0]   a;
    logic [LB-1:0] d;
    won_dc    = bus.dc_req_i && (!bus.ic_req_i || !m_last_dc);
    m_last_dc = won_dc;
    a         = won_dc ? bus.dc_addr_i : bus.ic_addr_i;
    m_addr    = (a / LINE_BYTES) * LINE_BYTES;
    d         = {$urandom, $urandom};
    n         = respond ? lat + 1 : TO;
    tick();
    chk("re_pulse",   64'(bus.l2_re_o), 64'd1);
    chk("grant_addr", 64'(bus.l2_addr_o), 64'(m_addr));
    chk("grant_busy", 64'(busy), 64'd1);
    chk("grant_no_ready", 64'(bus.ic_ready_o | bus.dc_ready_o), 64'd0);
    for (int j = 1; j <= n; j++) begin
      if (respond && j == n) begin
        bus.l2_data_ready_i = 1'b1;
        bus.l2_data_i       = d;
      end else begin
        bus.l2_data_i       = {$urandom, $urandom};
      end
      if (kill_run) run = 1'b0;
      else if ($urandom_range(0, 2) == 0) run = ~run;
      tick();
      bus.l2_data_ready_i = 1'b0;
      if (j < n) begin
        chk("wait_re_low", 64'(bus.l2_re_o), 64'd0);
        chk("wait_busy",   64'(busy), 64'd1);
        chk("wait_no_ready", 64'(bus.ic_ready_o | bus.dc_ready_o), 64'd0);
      end
    end
    m_data[int'(won_dc)] = respond ? d : '0;
    if (!respond) m_err = 1'b1;
    chk("resp_ic_ready", 64'(bus.ic_ready_o), 64'(!won_dc));
    chk("resp_dc_ready", 64'(bus.dc_ready_o), 64'(won_dc));
    chk("resp_ic_data",  bus.ic_data_o, m_data[0]);
    chk("resp_dc_data",  bus.dc_data_o, m_data[1]);
    chk("resp_err",      64'(err), 64'(m_err));
    chk("resp_busy",     64'(busy), 64'd1);
    chk("resp_re",       64'(bus.l2_re_o), 64'd0);
    if (won_dc) bus.dc_req_i = 1'b0;
    else        bus.ic_req_i = 1'b0;
    bus.l2_data_ready_i = 1'($urandom_range(0, 1));
    run = 1'b1;
    tick();
    bus.l2_data_ready_i = 1'b0;
    check_idle_outs("post_resp");
  endtask

  initial begin
    bit w;
    reset = 1'b1;
    run   = 1'b0;
    bus.ic_req_i = 1'b0;  bus.ic_addr_i = '0;
    bus.dc_req_i = 1'b0;  bus.dc_addr_i = '0;
    bus.l2_data_i = '0;   bus.l2_data_ready_i = 1'b0;
    model_reset();
    tick();
    tick();
    check_idle_outs("reset");
    reset = 1'b0;
    run   = 1'b1;

    // Single IC fill, L2 answers two cycles after the read pulse.
    bus.ic_req_i  = 1'b1;
    bus.ic_addr_i = 32'h0000_1234;
    do_fill(2, 1'b1, 1'b0, w);
    chk("t1_winner", 64'(w), 64'd0);
    chk("t1_addr",   64'(bus.l2_addr_o), 64'h1220);

    // Both requesting continuously after reset: strict alternation from IC.
    do_reset();
    bus.ic_req_i = 1'b1;  bus.ic_addr_i = $urandom;
    bus.dc_req_i = 1'b1;  bus.dc_addr_i = $urandom;
    for (int k = 0; k < 4; k++) begin
      do_fill($urandom_range(0, TO - 1), 1'b1, 1'b0, w);
      chk("rr_order", 64'(w), 64'(k % 2));
      if (w) begin bus.dc_req_i = 1'b1; bus.dc_addr_i = $urandom; end
      else   begin bus.ic_req_i = 1'b1; bus.ic_addr_i = $urandom; end
    end
    bus.ic_req_i = 1'b0;
    bus.dc_req_i = 1'b0;
    idle_tick();

    // run_i low blocks the grant; dropping it mid-WAIT does not stop the fill.
    run = 1'b0;
    bus.ic_req_i = 1'b1;
    bus.ic_addr_i = $urandom;
    repeat (3) idle_tick();
    run = 1'b1;
    do_fill(1, 1'b1, 1'b1, w);
    chk("run_winner", 64'(w), 64'd0);

    // Watchdog: L2 never answers; err sticks across later good fills.
    bus.ic_req_i = 1'b1;
    bus.ic_addr_i = $urandom;
    do_fill(0, 1'b0, 1'b0, w);
    chk("wd_err",     64'(err), 64'd1);
    chk("wd_ic_data", bus.ic_data_o, '0);
    bus.dc_req_i = 1'b1;
    bus.dc_addr_i = $urandom;
    do_fill(TO - 1, 1'b1, 1'b0, w);
    chk("wd_sticky",  64'(err), 64'd1);

    // Ready coinciding with the last watchdog cycle wins.
    do_reset();
    bus.ic_req_i = 1'b1;
    bus.ic_addr_i = $urandom;
    do_fill(TO - 1, 1'b1, 1'b0, w);
    chk("edge_no_err", 64'(err), 64'd0);

    // Randomized traffic.
    for (int it = 0; it < 120; it++) begin
      if (!bus.ic_req_i && $urandom_range(0, 2) != 0) begin
        bus.ic_req_i = 1'b1; bus.ic_addr_i = $urandom;
      end
      if (!bus.dc_req_i && $urandom_range(0, 2) != 0) begin
        bus.dc_req_i = 1'b1; bus.dc_addr_i = $urandom;
      end
      run = ($urandom_range(0, 4) != 0);
      if (run && (bus.ic_req_i || bus.dc_req_i))
        do_fill($urandom_range(0, TO - 1), $urandom_range(0, 5) != 0, 1'b0, w);
      else
        idle_tick();
    end

    // Reset mid-WAIT, then a stray L2 pulse must not produce a ready.
    run = 1'b1;
    bus.ic_req_i = 1'b1;
    bus.dc_req_i = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    bus.ic_req_i = 1'b0;
    bus.dc_req_i = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
    bus.l2_data_ready_i = 1'b1;
    bus.l2_data_i = {$urandom, $urandom};
    tick();
    bus.l2_data_ready_i = 1'b0;
    check_idle_outs("mid_wait_rst");
    tick();
    check_idle_outs("mid_wait_rst2");
    bus.ic_req_i = 1'b1;  bus.ic_addr_i = $urandom;
    bus.dc_req_i = 1'b1;  bus.dc_addr_i = $urandom;
    do_fill(0, 1'b1, 1'b0, w);
    chk("rst_tie_ic", 64'(w), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/l2_fill_arbiter.md
# l2_fill_arbiter

Shares the single L2 line-fill port between the I-cache and D-cache miss paths. It accepts at most one outstanding fill at a time and forwards the winning requester's line-aligned address to L2 as a one-cycle read pulse. It waits for L2's data-ready pulse, then returns the captured line to the owning requester. It sits between the L1 miss handlers and the L2 model, with round-robin fairness and a watchdog for lost responses.

## Interface
- LINE_BITS, 256: width of one cache line returned by L2.
- OFFSET_BITS, 5: low address bits forced to zero on the forwarded address (line alignment).
- TIMEOUT, 64: maximum WAIT cycles before the watchdog fires; must be ≥ 1.

Ports:
- Reset is `reset`: synchronous, active-high. Clock is `clk`.
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- run_i  in  1  when low, no new grant is issued; an in-flight fill still completes.
- ic_req_i  in  1  I-cache fill request, level, held until ic_ready_o.
- ic_addr_i  in  32  I-cache miss address, stable while ic_req_i is high.
- ic_data_o  out  LINE_BITS  returned line, valid while ic_ready_o is high.
- ic_ready_o  out  1  one-cycle completion pulse.
- dc_req_i / dc_addr_i / dc_data_o / dc_ready_o: same as the I-cache ports, for the D-cache.
- l2_addr_o  out  32  address to L2, line-aligned, held from grant until the next grant.
- l2_re_o  out  1  one-cycle read pulse to L2.
- l2_data_i  in  LINE_BITS  L2 line data, valid with l2_data_ready_i.
- l2_data_ready_i  in  1  L2 completion pulse.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- Three states: IDLE, WAIT, RESP.
- **IDLE**
  - If run_i and any request are high, register the owner, l2_addr_o = {addr[31:OFFSET_BITS], OFFSET_BITS'b0} and l2_re_o = 1, then go to WAIT.
  - Otherwise stay in IDLE with l2_re_o = 0.
- **Arbitration**
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant.
  - last_grant updates on every grant; its reset value is DC, so IC wins the first tie.
- **WAIT**
  - l2_re_o = 0 from the second WAIT cycle on; it is high for exactly one cycle per grant.
  - l2_data_ready_i is sampled only in WAIT and ignored in IDLE and RESP.
  - On l2_data_ready_i = 1: capture l2_data_i into the owner's data register, assert the owner's ready_o, and go to RESP.
- **Watchdog**
  - A counter clears on grant and increments on each WAIT cycle without ready.
  - When it reaches TIMEOUT: set err_o, return all-zero data with the owner's ready_o asserted, and go to RESP.
  - If ready and timeout coincide, ready wins and err_o is not set.
- **RESP**
  - Lasts one cycle; ready_o is high in this cycle only. Requests are not sampled. Then go to IDLE.
  - The requester must drop req within one cycle of seeing ready. The IDLE cycle after RESP therefore sees the updated request level.
- **Data holding:** ic_data_o and dc_data_o hold their last captured value between fills. Only the owner's register is written.
- **run_i low**
  - Blocks only the IDLE→WAIT transition.
  - WAIT and RESP proceed normally and the watchdog keeps counting.
- **Reset**
  - Synchronous reset forces IDLE from any state, including mid-WAIT; an L2 pulse arriving after reset is ignored.
  - Reset values: all ready_o = 0, l2_re_o = 0, busy_o = 0, err_o = 0, l2_addr_o = 0, data outputs = 0, last_grant = DC, watchdog counter = 0.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Request high before clock edge k while in IDLE: l2_re_o and l2_addr_o are valid in cycle k (the cycle after edge k).
- l2_data_ready_i sampled high at edge m: the owner's ready_o and data are valid in cycle m. The following cycle is IDLE.
- Minimum spacing between two grants is 3 cycles, given an L2 response one cycle after the re pulse.
- Back-to-back requesters alternate under round-robin; neither can be starved.

## Test plan
- **Single IC fill.** ic_req with addr 0x0000_1234; L2 returns data D two cycles after l2_re_o.
  - l2_addr_o = 0x0000_1220 and l2_re_o is high for one cycle.
  - ic_ready_o pulses once with ic_data_o = D; dc_ready_o stays 0.
- **Simultaneous requests after reset.** ic and dc both request; each requester drops req after its ready and re-raises it.
  - Grants go IC, DC, IC, DC, and each fill returns to the correct port.
- **run_i low.** run_i = 0 with ic_req high: no l2_re_o and busy_o = 0.
  - Drop run_i mid-WAIT: the fill still completes.
- **Watchdog.** TIMEOUT = 4 and L2 never responds.
  - After 4 WAIT cycles, err_o = 1, ic_ready_o pulses, and ic_data_o = 0.
  - err_o stays high through subsequent normal fills until reset.
- **Reset mid-WAIT.** Assert reset during WAIT, then pulse l2_data_ready_i.
  - All outputs return to 0 and no ready pulse appears.
  - The next request issues normally, and IC wins a tie.
- **Spurious L2 pulse.** Pulse l2_data_ready_i while in IDLE.
  - No ready pulse and no state change.
